// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared bit-plane memory word layout and sizing helpers
// Purpose: definitions shared by the framebuffer writer and the LED panel driver.
//   MEM_DATA_WIDTH  width of one bit-plane word {R0,G0,B0,R1,G1,B1}
//   POS_*           bit positions inside that word (0 = upper half row, 1 = lower half row)
//   wr_state_t      writer FSM states
//   mem_addr_width  half-frame word address width for a given panel size
//   mem_bit_width   plane index width for a given bit depth
//   pack_word       replicate one {r,g,b} triple into both halves of a word
package led_pkg;

  localparam int MEM_DATA_WIDTH = 6;
  localparam int PIX_WIDTH      = 24;
  localparam int COLOR_BITS     = 8;

  localparam int POS_R0 = 5;
  localparam int POS_G0 = 4;
  localparam int POS_B0 = 3;
  localparam int POS_R1 = 2;
  localparam int POS_G1 = 1;
  localparam int POS_B1 = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_t;

  // Upper and lower half rows share one word, so a frame needs rows*cols/2 words.
  function automatic int mem_addr_width(input int n_rows, input int n_cols);
    return $clog2(n_rows * n_cols) - 1;
  endfunction

  function automatic int mem_bit_width(input int bitdepth);
    return (bitdepth > 1) ? $clog2(bitdepth) : 1;
  endfunction

  // The same colour bits go to both halves; mem_we decides which half lands.
  function automatic logic [MEM_DATA_WIDTH-1:0] pack_word(input logic r, input logic g,
                                                          input logic b);
    logic [MEM_DATA_WIDTH-1:0] w;
    w         = '0;
    w[POS_R0] = r;
    w[POS_G0] = g;
    w[POS_B0] = b;
    w[POS_R1] = r;
    w[POS_G1] = g;
    w[POS_B1] = b;
    return w;
  endfunction

endpackage

// File: rtl/led_plane_slicer.sv
// rtl/led_plane_slicer.sv - selects one bit-plane {r,g,b} out of an RGB888 pixel
// Purpose: combinational bit-plane extraction with MSB-aligned truncation.
// Ports:
//   pix    in  24  {R[7:0],G[7:0],B[7:0]}
//   plane  in  3   plane index, 0 = LSB plane actually stored
//   depth  in  3   planes stored, modulo 8 (8 is passed as 0)
//   rgb    out 3   {r,g,b} bit of the selected plane
module led_plane_slicer
  import led_pkg::*;
(
  input  logic [PIX_WIDTH-1:0] pix,
  input  logic [2:0]           plane,
  input  logic [2:0]           depth,
  output logic [2:0]           rgb
);

  logic [2:0]            idx;
  logic [COLOR_BITS-1:0] r_byte;
  logic [COLOR_BITS-1:0] g_byte;
  logic [COLOR_BITS-1:0] b_byte;

  always_comb begin
    // Source bit is 8 - depth + plane; modulo 8 that is plane - depth, which
    // also makes depth = 8 (encoded as 0) map plane b straight to bit b.
    idx    = plane - depth;
    r_byte = pix[23:16];
    g_byte = pix[15:8];
    b_byte = pix[7:0];
    rgb    = {r_byte[idx], g_byte[idx], b_byte[idx]};
  end

endmodule

// File: rtl/led_fb_writer.sv
// rtl/led_fb_writer.sv - raster RGB888 stream to double-buffered bit-plane BRAM writer
// Purpose: accepts one pixel, writes its bit-planes one per cycle, walks the raster
//   with a running row base address and flips the write buffer on frame completion.
// Ports:
//   clk, ctrl_rst            clock, synchronous active-high reset
//   ctrl_en                  low = stop accepting pixels
//   ctrl_n_rows/n_cols       panel geometry (rows even)
//   ctrl_bitdepth            planes stored per colour, 1..BITDEPTH_MAX
//   s_pix_valid/ready/data/last   pixel stream, ready registered
//   mem_clk/en/we/buffer/addr/bit/dout   bit-plane memory write port
//   wr_buffer                buffer being written (driver shows the other one)
//   frame_done               1-cycle pulse on buffer flip
//   err_len                  sticky s_pix_last position mismatch
module led_fb_writer
  import led_pkg::*;
#(
  parameter int N_ROWS_MAX       = 64,
  parameter int N_COLS_MAX       = 256,
  parameter int BITDEPTH_MAX     = 8,
  parameter int CTRL_REG_WIDTH   = 32,
  parameter int MEM_W_ADDR_WIDTH = mem_addr_width(N_ROWS_MAX, N_COLS_MAX),
  parameter int MEM_BIT_WIDTH    = mem_bit_width(BITDEPTH_MAX)
) (
  input  logic                        clk,
  input  logic                        ctrl_rst,
  input  logic                        ctrl_en,
  input  logic [CTRL_REG_WIDTH-1:0]   ctrl_n_rows,
  input  logic [CTRL_REG_WIDTH-1:0]   ctrl_n_cols,
  input  logic [CTRL_REG_WIDTH-1:0]   ctrl_bitdepth,
  input  logic                        s_pix_valid,
  output logic                        s_pix_ready,
  input  logic [PIX_WIDTH-1:0]        s_pix_data,
  input  logic                        s_pix_last,
  output logic                        mem_clk,
  output logic                        mem_en,
  output logic [1:0]                  mem_we,
  output logic                        mem_buffer,
  output logic [MEM_W_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_BIT_WIDTH-1:0]    mem_bit,
  output logic [MEM_DATA_WIDTH-1:0]   mem_dout,
  output logic                        wr_buffer,
  output logic                        frame_done,
  output logic                        err_len
);

  localparam int ROW_W   = $clog2(N_ROWS_MAX) + 1;
  localparam int COL_W   = $clog2(N_COLS_MAX) + 1;
  localparam int DEPTH_W = MEM_BIT_WIDTH + 1;
  localparam int AW      = MEM_W_ADDR_WIDTH;

  wr_state_t              state;
  logic [PIX_WIDTH-1:0]   pix_q;
  logic                   last_q;
  logic [MEM_BIT_WIDTH-1:0] plane;
  logic [ROW_W-1:0]       row;
  logic [COL_W-1:0]       col;
  logic [AW-1:0]          base;

  logic [ROW_W-1:0]       n_rows;
  logic [ROW_W-1:0]       half;
  logic [COL_W-1:0]       n_cols;
  logic [DEPTH_W-1:0]     depth;
  logic [ROW_W-1:0]       row_inc;
  logic                   upper;
  logic                   row_last;
  logic                   col_last;
  logic                   plane_done;
  logic [AW-1:0]          addr_now;
  logic [PIX_WIDTH-1:0]   slice_pix;
  logic [MEM_BIT_WIDTH-1:0] slice_plane;
  logic [2:0]             slice_rgb;

  assign mem_clk = clk;

  // Out-of-range configuration is clamped so counters never run past the arrays.
  always_comb begin
    n_rows = (ctrl_n_rows > CTRL_REG_WIDTH'(N_ROWS_MAX)) ? ROW_W'(N_ROWS_MAX)
                                                          : ctrl_n_rows[ROW_W-1:0];
    n_cols = (ctrl_n_cols > CTRL_REG_WIDTH'(N_COLS_MAX)) ? COL_W'(N_COLS_MAX)
                                                          : ctrl_n_cols[COL_W-1:0];
    if (ctrl_bitdepth == '0) begin
      depth = DEPTH_W'(1);
    end else if (ctrl_bitdepth > CTRL_REG_WIDTH'(BITDEPTH_MAX)) begin
      depth = DEPTH_W'(BITDEPTH_MAX);
    end else begin
      depth = ctrl_bitdepth[DEPTH_W-1:0];
    end
    half       = n_rows >> 1;
    row_inc    = row + ROW_W'(1);
    upper      = (row < half);
    row_last   = (row == n_rows - ROW_W'(1));
    col_last   = (col == n_cols - COL_W'(1));
    plane_done = ({1'b0, plane} + DEPTH_W'(1)) == depth;
    addr_now   = base + AW'(col);
    // In IDLE the slicer looks at the incoming pixel so plane 0 is presented
    // the cycle right after the handshake; in WRITE it looks one plane ahead.
    if (state == ST_IDLE) begin
      slice_pix   = s_pix_data;
      slice_plane = '0;
    end else begin
      slice_pix   = pix_q;
      slice_plane = plane + MEM_BIT_WIDTH'(1);
    end
  end

  led_plane_slicer u_slicer (
    .pix   (slice_pix),
    .plane (3'(slice_plane)),
    .depth (depth[2:0]),
    .rgb   (slice_rgb)
  );

  always_ff @(posedge clk) begin
    if (ctrl_rst) begin
      state       <= ST_IDLE;
      s_pix_ready <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 2'b00;
      mem_buffer  <= 1'b0;
      mem_addr    <= '0;
      mem_bit     <= '0;
      mem_dout    <= '0;
      wr_buffer   <= 1'b0;
      frame_done  <= 1'b0;
      err_len     <= 1'b0;
      pix_q       <= '0;
      last_q      <= 1'b0;
      plane       <= '0;
      row         <= '0;
      col         <= '0;
      base        <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_pix_valid && s_pix_ready) begin
            pix_q       <= s_pix_data;
            last_q      <= s_pix_last;
            s_pix_ready <= 1'b0;
            plane       <= '0;
            mem_en      <= 1'b1;
            mem_we      <= upper ? 2'b10 : 2'b01;
            mem_buffer  <= wr_buffer;
            mem_addr    <= addr_now;
            mem_bit     <= slice_plane;
            mem_dout    <= pack_word(slice_rgb[2], slice_rgb[1], slice_rgb[0]);
            state       <= ST_WRITE;
          end else begin
            s_pix_ready <= ctrl_en;
          end
        end
        ST_WRITE: begin
          if (plane_done) begin
            mem_en      <= 1'b0;
            mem_we      <= 2'b00;
            s_pix_ready <= ctrl_en;
            state       <= ST_IDLE;
            if (row_last && col_last) begin
              wr_buffer  <= ~wr_buffer;
              frame_done <= 1'b1;
              if (!last_q) begin
                err_len <= 1'b1;
              end
              row  <= '0;
              col  <= '0;
              base <= '0;
            end else if (last_q) begin
              // Early end: restart the raster; the partial frame gets overwritten.
              err_len <= 1'b1;
              row     <= '0;
              col     <= '0;
              base    <= '0;
            end else if (col_last) begin
              col  <= '0;
              row  <= row_inc;
              // Lower half restarts at word 0 of the same buffer.
              base <= (row_inc == half) ? '0 : base + AW'(n_cols);
            end else begin
              col <= col + COL_W'(1);
            end
          end else begin
            plane    <= slice_plane;
            mem_bit  <= slice_plane;
            mem_dout <= pack_word(slice_rgb[2], slice_rgb[1], slice_rgb[0]);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_fb_writer.sv
// tb/tb_led_fb_writer.sv - self-checking bench for led_fb_writer against a raster model
module tb_led_fb_writer;

  logic        clk = 1'b0;
  logic        ctrl_rst;
  logic        ctrl_en;
  logic [31:0] ctrl_n_rows;
  logic [31:0] ctrl_n_cols;
  logic [31:0] ctrl_bitdepth;
  logic        s_pix_valid;
  logic        s_pix_ready;
  logic [23:0] s_pix_data;
  logic        s_pix_last;
  logic        mem_clk;
  logic        mem_en;
  logic [1:0]  mem_we;
  logic        mem_buffer;
  logic [12:0] mem_addr;
  logic [2:0]  mem_bit;
  logic [5:0]  mem_dout;
  logic        wr_buffer;
  logic        frame_done;
  logic        err_len;

  led_fb_writer dut (
    .clk           (clk),
    .ctrl_rst      (ctrl_rst),
    .ctrl_en       (ctrl_en),
    .ctrl_n_rows   (ctrl_n_rows),
    .ctrl_n_cols   (ctrl_n_cols),
    .ctrl_bitdepth (ctrl_bitdepth),
    .s_pix_valid   (s_pix_valid),
    .s_pix_ready   (s_pix_ready),
    .s_pix_data    (s_pix_data),
    .s_pix_last    (s_pix_last),
    .mem_clk       (mem_clk),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_buffer    (mem_buffer),
    .mem_addr      (mem_addr),
    .mem_bit       (mem_bit),
    .mem_dout      (mem_dout),
    .wr_buffer     (wr_buffer),
    .frame_done    (frame_done),
    .err_len       (err_len)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         due;
    logic [12:0] addr;
    logic [1:0] we;
    logic [2:0] bitn;
    logic [5:0] dout;
    logic       bufv;
  } wr_t;

  typedef struct {
    int   due;
    logic fd;
    logic bufv;
    logic err;
  } ev_t;

  typedef struct {
    logic [12:0] addr;
    logic [1:0]  we;
    logic [2:0]  bitn;
    logic [5:0]  dout;
  } log_t;

  wr_t  wq[$];
  ev_t  eq[$];
  log_t wlog[$];
  int   hs_log[$];
  int   cyc = 0;
  int   busy_until = 0;
  int   fd_count = 0;
  int   mk = 0;
  logic mbuf = 1'b0;
  logic merr = 1'b0;
  logic en_prev = 1'b0;
  logic rst_prev = 1'b1;

  // Raster model: pixel k of a frame sits at row k/cols, col k%cols.
  task automatic model_push(input logic [23:0] p, input logic l);
    int rows = ctrl_n_rows;
    int cols = ctrl_n_cols;
    int d    = ctrl_bitdepth;
    int half = rows / 2;
    int r    = mk / cols;
    int c    = mk % cols;
    int rr   = (r < half) ? r : r - half;
    logic fd;
    wr_t w;
    for (int b = 0; b < d; b++) begin
      int sh = 8 - d + b;
      logic [2:0] rgb;
      rgb    = {p[16+sh], p[8+sh], p[sh]};
      w.due  = cyc + 1 + b;
      w.addr = 13'(rr * cols + c);
      w.we   = (r < half) ? 2'b10 : 2'b01;
      w.bitn = 3'(b);
      w.dout = {rgb, rgb};
      w.bufv = mbuf;
      wq.push_back(w);
    end
    if (mk == rows * cols - 1) begin
      if (!l) merr = 1'b1;
      mbuf = ~mbuf;
      fd   = 1'b1;
      mk   = 0;
    end else if (l) begin
      merr = 1'b1;
      fd   = 1'b0;
      mk   = 0;
    end else begin
      fd = 1'b0;
      mk++;
    end
    eq.push_back('{cyc + d + 1, fd, mbuf, merr});
    busy_until = cyc + d;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (wq.size() > 0 && wq[0].due == cyc) begin
      chk("mem_en", mem_en, 1);
      chk("mem_addr", mem_addr, wq[0].addr);
      chk("mem_we", mem_we, wq[0].we);
      chk("mem_bit", mem_bit, wq[0].bitn);
      chk("mem_dout", mem_dout, wq[0].dout);
      chk("mem_buffer", mem_buffer, wq[0].bufv);
      void'(wq.pop_front());
    end else begin
      chk("mem_en_idle", mem_en, 0);
    end
    if (eq.size() > 0 && eq[0].due == cyc) begin
      chk("frame_done", frame_done, eq[0].fd);
      chk("wr_buffer", wr_buffer, eq[0].bufv);
      chk("err_len", err_len, eq[0].err);
      void'(eq.pop_front());
    end else begin
      chk("frame_done_idle", frame_done, 0);
    end
    if (cyc <= busy_until || rst_prev) chk("ready_low", s_pix_ready, 0);
    else chk("ready_en", s_pix_ready, en_prev);
    if (mem_en) wlog.push_back('{mem_addr, mem_we, mem_bit, mem_dout});
    if (frame_done) fd_count++;
    if (ctrl_rst) begin
      wq.delete();
      eq.delete();
      mk = 0;
      mbuf = 1'b0;
      merr = 1'b0;
      busy_until = cyc;
    end else if (s_pix_valid && s_pix_ready) begin
      hs_log.push_back(cyc);
      model_push(s_pix_data, s_pix_last);
    end
    rst_prev = ctrl_rst;
    en_prev  = ctrl_en;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [23:0] p, input logic l);
    bit ok;
    ok = 1'b0;
    s_pix_valid = 1'b1;
    s_pix_data  = p;
    s_pix_last  = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_pix_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_pix_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: got ready=0 want ready=1 at %0t", $time);
    end
  endtask

  task automatic do_reset(input int rows, input int cols, input int d);
    ctrl_rst      = 1'b1;
    ctrl_n_rows   = rows;
    ctrl_n_cols   = cols;
    ctrl_bitdepth = d;
    step(2);
    ctrl_rst = 1'b0;
    step(1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d4;
    int d5;
    ctrl_rst      = 1'b1;
    ctrl_en       = 1'b1;
    ctrl_n_rows   = 4;
    ctrl_n_cols   = 2;
    ctrl_bitdepth = 8;
    s_pix_valid   = 1'b0;
    s_pix_data    = '0;
    s_pix_last    = 1'b0;
    step(3);
    chk("rst_ready", s_pix_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_wr_buffer", wr_buffer, 0);
    chk("rst_err_len", err_len, 0);
    ctrl_rst = 1'b0;
    step(1);

    // Frame of 4x2 at depth 8: literal pins for pixel (0,0) and (2,1).
    wlog.delete();
    fd_count = 0;
    for (int i = 0; i < 8; i++) begin
      logic [23:0] p;
      p = (i == 0) ? 24'h800001 : (i == 5) ? 24'hFFFFFF : 24'($urandom);
      send_pixel(p, i == 7);
    end
    step(12);
    chk("t1_count", wlog.size(), 64);
    chk("t1_p7_dout", wlog[7].dout[5:3], 3'b100);
    chk("t1_p7_addr", wlog[7].addr, 0);
    chk("t1_p7_we", wlog[7].we, 2'b10);
    chk("t1_p0_dout", wlog[0].dout[5:3], 3'b001);
    chk("t1_frame_done", fd_count, 1);
    chk("t1_wr_buffer", wr_buffer, 1);
    for (int b = 0; b < 8; b++) begin
      chk("t2_addr", wlog[40+b].addr, 1);
      chk("t2_we", wlog[40+b].we, 2'b01);
      chk("t2_dout", wlog[40+b].dout[2:0], 3'b111);
      chk("t2_bit", wlog[40+b].bitn, b);
    end

    // Depth 4, back-to-back pixels.
    do_reset(4, 2, 4);
    wlog.delete();
    hs_log.delete();
    for (int i = 0; i < 8; i++) send_pixel((i == 0) ? 24'hA00000 : 24'($urandom), i == 7);
    step(8);
    chk("t3_r_pl0", wlog[0].dout[5], 0);
    chk("t3_r_pl1", wlog[1].dout[5], 1);
    chk("t3_r_pl2", wlog[2].dout[5], 0);
    chk("t3_r_pl3", wlog[3].dout[5], 1);
    chk("t3_period", hs_log[1] - hs_log[0], 5);

    // Early s_pix_last, then a good frame.
    d4 = $urandom_range(3, 8);
    do_reset(4, 2, d4);
    fd_count = 0;
    for (int i = 0; i < 5; i++) send_pixel(24'($urandom), i == 4);
    step(12);
    chk("t4_err_len", err_len, 1);
    chk("t4_no_flip", wr_buffer, 0);
    chk("t4_no_fd", fd_count, 0);
    for (int i = 0; i < 8; i++) send_pixel(24'($urandom), i == 7);
    step(12);
    chk("t4_flip", wr_buffer, 1);
    chk("t4_fd_once", fd_count, 1);

    // Reset on the third plane write.
    send_pixel(24'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (mem_en && mem_bit == 3'd2) break;
      step(1);
    end
    chk("t5_at_plane2", mem_bit, 2);
    ctrl_rst = 1'b1;
    step(1);
    chk("t5_mem_en", mem_en, 0);
    chk("t5_wr_buffer", wr_buffer, 0);
    ctrl_rst = 1'b0;
    step(1);
    wlog.delete();
    send_pixel(24'($urandom), 1'b0);
    step(12);
    chk("t5_count", wlog.size(), d4);
    chk("t5_addr", wlog[0].addr, 0);
    chk("t5_bit", wlog[0].bitn, 0);

    // ctrl_en drop during a write.
    d5 = d4;
    wlog.delete();
    send_pixel(24'($urandom), 1'b0);
    ctrl_en = 1'b0;
    step(15);
    chk("t6_count", wlog.size(), d5);
    chk("t6_ready_off", s_pix_ready, 0);
    ctrl_en = 1'b1;
    step(2);
    chk("t6_ready_on", s_pix_ready, 1);

    // Randomised geometry, depth and s_pix_last placement.
    for (int it = 0; it < 6; it++) begin
      int rows;
      int cols;
      int d;
      rows = (it == 0) ? 2 : 2 * $urandom_range(1, 4);
      cols = (it == 0) ? 1 : $urandom_range(1, 4);
      d    = (it == 0) ? 1 : $urandom_range(1, 8);
      do_reset(rows, cols, d);
      for (int f = 0; f < 3; f++) begin
        int n;
        int mode;
        int stop_at;
        n       = rows * cols;
        mode    = $urandom_range(0, 7);
        stop_at = (mode == 0) ? $urandom_range(0, n - 1) : n - 1;
        for (int i = 0; i <= stop_at; i++) begin
          logic l;
          l = (mode == 1) ? 1'b0 : (i == stop_at);
          if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
          send_pixel(24'($urandom), l);
        end
      end
      step(12);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
